vote_session_ctrl: RTL and testbench



---
 rtl/vote_pkg.sv | 9 +
 rtl/voter_tally.sv | 26 ++
 rtl/vote_session_ctrl.sv | 104 ++++++++++
 tb/tb_vote_session_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: state type, default sizing and count-width helper for the voting session block
package vote_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, TALLY, DONE} state_t;
    localparam int DEF_N_VOTERS = 4;
    localparam int DEF_TIMEOUT = 255;
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/voter_tally.sv
// voter_tally: combinational yes/no/abstain popcount with majority and tie flags
// ports: ballot, voted in; yes, no, abstain, pass, tie out
module voter_tally import vote_pkg::*; #(
    parameter int N_VOTERS = DEF_N_VOTERS,
    parameter int CNT_W = cnt_width(N_VOTERS)
) (
    input  logic [N_VOTERS-1:0] ballot,
    input  logic [N_VOTERS-1:0] voted,
    output logic [CNT_W-1:0]    yes,
    output logic [CNT_W-1:0]    no,
    output logic [CNT_W-1:0]    abstain,
    output logic                pass,
    output logic                tie
);
    always_comb begin
        yes = '0;
        no = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            yes = yes + CNT_W'(voted[i] & ballot[i]);
            no = no + CNT_W'(voted[i] & ~ballot[i]);
        end
    end
    assign abstain = CNT_W'(N_VOTERS) - yes - no;
    assign pass = yes > CNT_W'(N_VOTERS / 2);
    assign tie = yes == no;
endmodule

// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: sequences one voting session (collect window, tally, done pulse)
// ports: clk, rst, start, vote_valid, vote_yes in; busy, voted, done, pass, tie,
//        yes_cnt, no_cnt, abstain_cnt, timed_out out
// VOTE_CHANGE_EN: later ballots overwrite earlier ones and the window always runs to the timer
module vote_session_ctrl import vote_pkg::*; #(
    parameter int N_VOTERS = DEF_N_VOTERS,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W = cnt_width(N_VOTERS),
    parameter int TMR_W = $clog2(TIMEOUT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    output logic                busy,
    output logic [N_VOTERS-1:0] voted,
    output logic                done,
    output logic                pass,
    output logic                tie,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic [CNT_W-1:0]    no_cnt,
    output logic [CNT_W-1:0]    abstain_cnt,
    output logic                timed_out
);
    state_t state;
    logic [N_VOTERS-1:0] ballot, take, nxt_voted, nxt_ballot;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] t_yes, t_no, t_abs;
    logic t_pass, t_tie, tmr_end, close, close_to, to_flag;
`ifdef VOTE_CHANGE_EN
    assign take = vote_valid;
    assign close = tmr_end;
    assign close_to = 1'b1;
`else
    // all-voted takes priority over the timer when both land in the same cycle
    assign take = vote_valid & ~voted;
    assign close = tmr_end | &nxt_voted;
    assign close_to = ~&nxt_voted;
`endif
    assign nxt_voted = voted | vote_valid;
    assign nxt_ballot = (ballot & ~take) | (vote_yes & take);
    assign tmr_end = timer == TMR_W'(TIMEOUT - 1);
    voter_tally #(.N_VOTERS(N_VOTERS), .CNT_W(CNT_W)) u_tally (
        .ballot(ballot), .voted(voted), .yes(t_yes), .no(t_no),
        .abstain(t_abs), .pass(t_pass), .tie(t_tie)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ballot <= '0;
            timer <= '0;
            to_flag <= 1'b0;
            voted <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            tie <= 1'b0;
            yes_cnt <= '0;
            no_cnt <= '0;
            abstain_cnt <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= COLLECT;
                    busy <= 1'b1;
                    voted <= '0;
                    ballot <= '0;
                    timer <= '0;
                    to_flag <= 1'b0;
                    pass <= 1'b0;
                    tie <= 1'b0;
                    yes_cnt <= '0;
                    no_cnt <= '0;
                    abstain_cnt <= '0;
                    timed_out <= 1'b0;
                end
                COLLECT: begin
                    voted <= nxt_voted;
                    ballot <= nxt_ballot;
                    timer <= timer + 1'b1;
                    to_flag <= close_to;
                    state <= close ? TALLY : COLLECT;
                end
                TALLY: begin
                    state <= DONE;
                    done <= 1'b1;
                    yes_cnt <= t_yes;
                    no_cnt <= t_no;
                    abstain_cnt <= t_abs;
                    pass <= t_pass;
                    tie <= t_tie;
                    timed_out <= to_flag;
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb_vote_session_ctrl: randomized and directed sessions checked against a ballot-box model
module tb_vote_session_ctrl;
    localparam int N = 4;
    localparam int T = 16;
    localparam int CW = $clog2(N + 1);
`ifdef VOTE_CHANGE_EN
    localparam bit CHG = 1'b1;
`else
    localparam bit CHG = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, start, busy, done, pass, tie, timed_out;
    logic [N-1:0] vote_valid, vote_yes, voted;
    logic [CW-1:0] yes_cnt, no_cnt, abstain_cnt;
    logic [N-1:0] s_vv [0:T+3];
    logic [N-1:0] s_vy [0:T+3];
    logic s_st [0:T+3];
    int n_vec = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    vote_session_ctrl #(.N_VOTERS(N), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote_yes(vote_yes),
        .busy(busy), .voted(voted), .done(done), .pass(pass), .tie(tie),
        .yes_cnt(yes_cnt), .no_cnt(no_cnt), .abstain_cnt(abstain_cnt), .timed_out(timed_out)
    );
    task chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task check_zero(input string tag);
        chk({tag, ":busy"}, busy, 0);
        chk({tag, ":voted"}, voted, 0);
        chk({tag, ":done"}, done, 0);
        chk({tag, ":pass"}, pass, 0);
        chk({tag, ":tie"}, tie, 0);
        chk({tag, ":yes"}, yes_cnt, 0);
        chk({tag, ":no"}, no_cnt, 0);
        chk({tag, ":abstain"}, abstain_cnt, 0);
        chk({tag, ":timed_out"}, timed_out, 0);
    endtask
    task clear_sched();
        for (int k = 0; k < T + 4; k++) begin
            s_vv[k] = '0;
            s_vy[k] = '0;
            s_st[k] = 1'b0;
        end
    endtask
    task run_session(input string name);
        logic [N-1:0] mv, mb;
        int ke, got, ey, en;
        bit ended, mto;
        mv = '0;
        mb = '0;
        ke = -1;
        got = -1;
        ended = 1'b0;
        mto = 1'b0;
        @(negedge clk);
        start = 1'b1;
        vote_valid = N'($urandom);
        vote_yes = N'($urandom);
        @(posedge clk);
        #1 chk({name, ":busy_rise"}, busy, 1);
        for (int k = 0; k < T + 4 && got < 0; k++) begin
            @(negedge clk);
            start = s_st[k];
            vote_valid = s_vv[k];
            vote_yes = s_vy[k];
            if (!ended) begin
                for (int i = 0; i < N; i++)
                    if (vote_valid[i] && (!mv[i] || CHG)) begin
                        mb[i] = vote_yes[i];
                        mv[i] = 1'b1;
                    end
                if (!CHG && mv == '1) begin
                    ended = 1'b1;
                    ke = k;
                end else if (k == T - 1) begin
                    ended = 1'b1;
                    ke = k;
                    mto = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            chk({name, ":voted"}, voted, mv);
            chk({name, ":busy"}, busy, 1);
            if (done) got = k + 1;
        end
        chk({name, ":done_cycle"}, got, ke + 2);
        ey = 0;
        en = 0;
        for (int i = 0; i < N; i++)
            if (mv[i]) begin
                if (mb[i]) ey++;
                else en++;
            end
        chk({name, ":yes"}, yes_cnt, ey);
        chk({name, ":no"}, no_cnt, en);
        chk({name, ":abstain"}, abstain_cnt, N - ey - en);
        chk({name, ":pass"}, pass, int'(ey > N / 2));
        chk({name, ":tie"}, tie, int'(ey == en));
        chk({name, ":timed_out"}, timed_out, mto);
        @(negedge clk);
        start = 1'b0;
        vote_valid = N'($urandom);
        vote_yes = N'($urandom);
        @(posedge clk);
        #1;
        chk({name, ":done_drop"}, done, 0);
        chk({name, ":busy_drop"}, busy, 0);
        chk({name, ":yes_hold"}, yes_cnt, ey);
        chk({name, ":no_hold"}, no_cnt, en);
        chk({name, ":voted_hold"}, voted, mv);
        chk({name, ":to_hold"}, timed_out, mto);
        @(negedge clk);
        vote_valid = '0;
    endtask
    task mid_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        vote_valid = 4'b0001;
        vote_yes = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        vote_valid = 4'b0010;
        vote_yes = 4'b0000;
        @(posedge clk);
        #1;
        chk("midrst:voted_pre", voted, 3);
        chk("midrst:busy_pre", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        vote_valid = '0;
        @(posedge clk);
        #1 check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("midrst:idle", busy, 0);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        vote_valid = '0;
        vote_yes = '0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        clear_sched();
        s_vv[0] = 4'b0001; s_vy[0] = 4'b0001;
        s_vv[1] = 4'b0010; s_vy[1] = 4'b0010; s_st[1] = 1'b1;
        s_vv[2] = 4'b0100; s_vy[2] = 4'b0100;
        s_vv[3] = 4'b1000; s_vy[3] = 4'b0000;
        run_session("seq4");
        clear_sched();
        s_vv[0] = 4'b1111; s_vy[0] = 4'b0011;
        run_session("all_at_once");
        clear_sched();
        s_vv[1] = 4'b0010; s_vy[1] = 4'b0010;
        run_session("timeout");
        clear_sched();
        s_vv[0] = 4'b0001; s_vy[0] = 4'b0001;
        s_vv[1] = 4'b0001; s_vy[1] = 4'b0000;
        s_vv[2] = 4'b1110; s_vy[2] = 4'b0000;
        run_session("revote");
        mid_reset();
        clear_sched();
        s_vv[0] = 4'b0100; s_vy[0] = 4'b0000;
        s_vv[2] = 4'b1011; s_vy[2] = 4'b1011;
        run_session("after_rst");
        clear_sched();
        s_vv[0] = 4'b0001; s_vy[0] = 4'b0001;
        s_vv[T-1] = 4'b1110; s_vy[T-1] = 4'b0110;
        run_session("last_cycle");
        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < T + 4; k++) begin
                s_vv[k] = N'($urandom) & N'($urandom) & N'($urandom);
                s_vy[k] = N'($urandom);
                s_st[k] = $urandom_range(0, 3) == 0;
            end
            run_session($sformatf("rand%0d", r));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
